// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common-data-bus arbiter.
// Defines package cdb_pkg, which is imported by the interface, the arbiter and the bench.
package cdb_pkg;

    localparam int RS_ID_WIDTH    = 5;
    localparam int GPR_ADDR_WIDTH = 5;
    localparam int DATA_WIDTH     = 32;

    typedef struct packed {
        logic [GPR_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     value;
        logic [RS_ID_WIDTH-1:0]    rs_id;
    } cdb_result_t;

    // Round-robin successor of idx; wrap_to is the first unit in the rotation.
    function automatic int next_unit(input int idx, input int num_units, input int wrap_to);
        return (idx + 1 >= num_units) ? wrap_to : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result handshake from the functional units and the registered CDB broadcast.
// master = functional-unit side, slave = arbiter side.
interface cdb_arbiter_if
    import cdb_pkg::*;
#(
    parameter int NUM_UNITS   = 4,
    parameter int RS_ID_WIDTH = 5
);
    localparam int UNIT_W = $clog2(NUM_UNITS);

    logic [NUM_UNITS-1:0]      req_valid;
    logic [NUM_UNITS-1:0]      req_ready;
    logic [GPR_ADDR_WIDTH-1:0] req_addr  [NUM_UNITS];
    logic [DATA_WIDTH-1:0]     req_value [NUM_UNITS];
    logic [RS_ID_WIDTH-1:0]    req_rs_id [NUM_UNITS];

    logic                      cdb_valid;
    logic [GPR_ADDR_WIDTH-1:0] cdb_addr;
    logic [DATA_WIDTH-1:0]     cdb_value;
    logic [RS_ID_WIDTH-1:0]    cdb_rs_id;
    logic [UNIT_W-1:0]         cdb_unit;

    modport master (
        output req_valid, req_addr, req_value, req_rs_id,
        input  req_ready, cdb_valid, cdb_addr, cdb_value, cdb_rs_id, cdb_unit
    );

    modport slave (
        input  req_valid, req_addr, req_value, req_rs_id,
        output req_ready, cdb_valid, cdb_addr, cdb_value, cdb_rs_id, cdb_unit
    );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: scans upward from i_ptr with wrap-around,
// returning a one-hot grant and its encoded index (both zero when nothing requests).
module rr_arbiter #(
    parameter int NUM_UNITS = 4
) (
    input  logic [NUM_UNITS-1:0]         i_req,
    input  logic [$clog2(NUM_UNITS)-1:0] i_ptr,
    output logic [NUM_UNITS-1:0]         o_grant,
    output logic [$clog2(NUM_UNITS)-1:0] o_idx
);
    localparam int IDX_W = $clog2(NUM_UNITS);

    function automatic logic [IDX_W-1:0] wrap(input int j);
        return IDX_W'((j >= NUM_UNITS) ? j - NUM_UNITS : j);
    endfunction

    always_comb begin
        // NOTE: every output gets a default before any conditional assignment,
        // so no path leaves a value unassigned and no latch is inferred.
        o_grant = '0;
        o_idx   = '0;
        // Scan farthest-first so the nearest requester is the last one written.
        for (int off = NUM_UNITS - 1; off >= 0; off--) begin
            if (i_req[wrap(int'(i_ptr) + off)]) begin
                o_grant                             = '0;
                o_grant[wrap(int'(i_ptr) + off)]    = 1'b1;
                o_idx                               = wrap(int'(i_ptr) + off);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants one functional-unit result per cycle and registers it onto the bus.
// Define CDB_FIXED_PRIO_EN to give unit 0 absolute priority over a 1..N-1 rotation.
module cdb_arbiter #(
    parameter int NUM_UNITS   = 4,
    parameter int RS_ID_WIDTH = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_flush,
    cdb_arbiter_if.slave   io_bus
);
    import cdb_pkg::*;

    localparam int UNIT_W = $clog2(NUM_UNITS);

    logic [NUM_UNITS-1:0] w_req;
    logic [NUM_UNITS-1:0] w_rr_req;
    logic [NUM_UNITS-1:0] w_rr_grant;
    logic [NUM_UNITS-1:0] w_grant;
    logic [UNIT_W-1:0]    w_rr_idx;
    logic [UNIT_W-1:0]    w_idx;
    logic                 w_any;
    cdb_result_t          w_sel;

    logic [UNIT_W-1:0]    r_rr_ptr;
    logic                 r_cdb_valid;
    logic [UNIT_W-1:0]    r_cdb_unit;
    cdb_result_t          r_cdb;

    // Reset and flush both suppress every handshake in the current cycle.
    assign w_req = (rst || i_flush) ? '0 : io_bus.req_valid;

`ifdef CDB_FIXED_PRIO_EN
    assign w_rr_req = w_req & ~NUM_UNITS'(1);
`else
    assign w_rr_req = w_req;
`endif

    rr_arbiter #(.NUM_UNITS(NUM_UNITS)) u_rr (
        .i_req   (w_rr_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_rr_grant),
        .o_idx   (w_rr_idx)
    );

    always_comb begin
        w_grant = w_rr_grant;
        w_idx   = w_rr_idx;
`ifdef CDB_FIXED_PRIO_EN
        if (w_req[0]) begin
            w_grant = NUM_UNITS'(1);
            w_idx   = '0;
        end
`endif
    end

    assign w_any = |w_grant;

    always_comb begin
        w_sel.addr  = io_bus.req_addr[w_idx];
        w_sel.value = io_bus.req_value[w_idx];
        w_sel.rs_id = io_bus.req_rs_id[w_idx];
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (rst) begin
            r_rr_ptr    <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_unit  <= '0;
            r_cdb       <= '0;
        end else begin
            r_cdb_valid <= w_any;
            if (w_any) begin
                r_cdb      <= w_sel;
                r_cdb_unit <= w_idx;
`ifdef CDB_FIXED_PRIO_EN
                if (w_idx != '0)
                    r_rr_ptr <= UNIT_W'(next_unit(int'(w_idx), NUM_UNITS, 1));
`else
                r_rr_ptr <= UNIT_W'(next_unit(int'(w_idx), NUM_UNITS, 0));
`endif
            end
        end
    end

    assign io_bus.req_ready = w_grant;
    assign io_bus.cdb_valid = r_cdb_valid;
    assign io_bus.cdb_addr  = r_cdb.addr;
    assign io_bus.cdb_value = r_cdb.value;
    assign io_bus.cdb_rs_id = RS_ID_WIDTH'(r_cdb.rs_id);
    assign io_bus.cdb_unit  = r_cdb_unit;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single grants, rotation, flush and mid-stream reset,
// plus the fixed-priority scenario when CDB_FIXED_PRIO_EN is defined.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int N  = 4;
    localparam int RW = 5;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_UNITS(N), .RS_ID_WIDTH(RW)) bus ();

    cdb_arbiter #(.NUM_UNITS(N), .RS_ID_WIDTH(RW)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .io_bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive(input int u, input logic v, input logic [4:0] a,
                         input logic [31:0] d, input logic [4:0] r);
        bus.req_valid[u] = v;
        bus.req_addr[u]  = a;
        bus.req_value[u] = d;
        bus.req_rs_id[u] = r;
    endtask

    // Each unit carries a recognisable payload derived from its index.
    task automatic drive_std(input int u, input logic v);
        drive(u, v, 5'(u + 10), 32'hA000_0000 + 32'(u), 5'(u + 20));
    endtask

    task automatic check_cdb(input string tag, input logic v, input int u);
        check({tag, ".cdb_valid"}, 32'(bus.cdb_valid), 32'(v));
        check({tag, ".cdb_unit"},  32'(bus.cdb_unit),  32'(u));
        if (v) begin
            check({tag, ".cdb_addr"},  32'(bus.cdb_addr),  32'(u + 10));
            check({tag, ".cdb_value"}, bus.cdb_value,      32'hA000_0000 + 32'(u));
            check({tag, ".cdb_rs_id"}, 32'(bus.cdb_rs_id), 32'(u + 20));
        end
    endtask

    initial begin
        for (int u = 0; u < N; u++) drive(u, 1'b0, '0, '0, '0);

        // Reset: a valid request must not be granted while rst is high.
        drive_std(1, 1'b1);
        cyc(); settle();
        check("rst_ready", 32'(bus.req_ready), 32'h0);
        cyc();
        rst = 1'b0;
        drive_std(1, 1'b0);
        settle();
        check("reset.cdb_valid", 32'(bus.cdb_valid), 32'h0);
        check("reset.cdb_addr",  32'(bus.cdb_addr),  32'h0);
        check("reset.cdb_value", bus.cdb_value,      32'h0);
        check("reset.cdb_rs_id", 32'(bus.cdb_rs_id), 32'h0);
        check("reset.cdb_unit",  32'(bus.cdb_unit),  32'h0);
        for (int k = 0; k < 5; k++) begin
            cyc(); settle();
            check("idle.cdb_valid", 32'(bus.cdb_valid), 32'h0);
            check("idle.ready",     32'(bus.req_ready), 32'h0);
        end

        // Unit 2 alone: same-cycle ready, one-cycle latency, then cdb_valid drops.
        cyc();
        drive(2, 1'b1, 5'd7, 32'hDEAD_BEEF, 5'd3);
        settle();
        check("u2.ready", 32'(bus.req_ready), 32'b0100);
        cyc();
        bus.req_valid[2] = 1'b0;
        settle();
        check("u2.cdb_valid", 32'(bus.cdb_valid), 32'h1);
        check("u2.cdb_addr",  32'(bus.cdb_addr),  32'd7);
        check("u2.cdb_value", bus.cdb_value,      32'hDEAD_BEEF);
        check("u2.cdb_rs_id", 32'(bus.cdb_rs_id), 32'd3);
        check("u2.cdb_unit",  32'(bus.cdb_unit),  32'd2);
        check("u2.ready_off", 32'(bus.req_ready), 32'h0);
        cyc(); settle();
        check("u2.cdb_drop",  32'(bus.cdb_valid), 32'h0);
        check("u2.addr_hold", 32'(bus.cdb_addr),  32'd7);
        check("u2.value_hold", bus.cdb_value,     32'hDEAD_BEEF);

`ifndef CDB_FIXED_PRIO_EN
        // Unit 3 alone for three cycles: granted every cycle; pointer ends at 0.
        cyc();
        drive_std(3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            settle();
            check("solo3.ready", 32'(bus.req_ready), 32'b1000);
            if (k > 0) check_cdb("solo3", 1'b1, 3);
            cyc();
        end

        // All units valid: grants rotate 0,1,2,3,0,1,2,3.
        for (int u = 0; u < N; u++) drive_std(u, 1'b1);
        for (int k = 0; k < 8; k++) begin
            settle();
            check("rot.ready", 32'(bus.req_ready), 32'(1) << (k % 4));
            check_cdb("rot", 1'b1, (k == 0) ? 3 : (k - 1) % 4);
            cyc();
        end
        for (int u = 0; u < N; u++) drive_std(u, 1'b0);
        settle();
        check_cdb("rot_last", 1'b1, 3);
        check("rot_last.ready", 32'(bus.req_ready), 32'h0);

        // Move pointer to 2 via unit 1, then units 1 and 3 contend: 3 first, then 1.
        cyc();
        drive_std(1, 1'b1);
        settle();
        check("p2.ready", 32'(bus.req_ready), 32'b0010);
        cyc();
        drive_std(3, 1'b1);
        settle();
        check("u13.first", 32'(bus.req_ready), 32'b1000);
        check_cdb("u13.prev", 1'b1, 1);
        cyc();
        drive_std(3, 1'b0);
        settle();
        check("u13.second", 32'(bus.req_ready), 32'b0010);
        check_cdb("u13.got3", 1'b1, 3);
        cyc();
        drive_std(1, 1'b0);
        settle();
        check_cdb("u13.got1", 1'b1, 1);

        // Flush with unit 0 valid and cdb_valid high.
        cyc();
        drive_std(0, 1'b1);
        settle();
        check("fl.pre_ready", 32'(bus.req_ready), 32'b0001);
        cyc();
        flush = 1'b1;
        settle();
        check("fl.ready", 32'(bus.req_ready), 32'h0);
        check_cdb("fl.cur", 1'b1, 0);
        cyc();
        flush = 1'b0;
        settle();
        check("fl.cdb_valid", 32'(bus.cdb_valid), 32'h0);
        check("fl.regrant", 32'(bus.req_ready), 32'b0001);
        cyc();
        drive_std(0, 1'b0);
        settle();
        check_cdb("fl.after", 1'b1, 0);

        // Reset mid-stream: pointer (1 here) returns to 0, so unit 0 beats unit 1 afterwards.
        cyc();
        drive_std(0, 1'b1);
        settle();
        check("mr.pre_ready", 32'(bus.req_ready), 32'b0001);
        cyc();
        rst = 1'b1;
        settle();
        check("mr.ready", 32'(bus.req_ready), 32'h0);
        check_cdb("mr.cur", 1'b1, 0);
        cyc();
        rst = 1'b0;
        drive_std(1, 1'b1);
        settle();
        check("mr.cdb_valid", 32'(bus.cdb_valid), 32'h0);
        check("mr.cdb_unit",  32'(bus.cdb_unit),  32'h0);
        check("mr.cdb_addr",  32'(bus.cdb_addr),  32'h0);
        check("mr.cdb_value", bus.cdb_value,      32'h0);
        check("mr.ptr_zero",  32'(bus.req_ready), 32'b0001);
        cyc();
        drive_std(0, 1'b0);
        settle();
        check_cdb("mr.got0", 1'b1, 0);
        check("mr.next", 32'(bus.req_ready), 32'b0010);
        cyc();
        drive_std(1, 1'b0);
        settle();
        check_cdb("mr.got1", 1'b1, 1);
`else
        // Fixed priority: unit 0 starves unit 1 until it drops valid.
        cyc();
        drive_std(0, 1'b1);
        drive_std(1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            settle();
            check("fp.ready", 32'(bus.req_ready), 32'b0001);
            if (k > 0) check_cdb("fp", 1'b1, 0);
            cyc();
        end
        drive_std(0, 1'b0);
        settle();
        check("fp.u1_ready", 32'(bus.req_ready), 32'b0010);
        check_cdb("fp.last0", 1'b1, 0);
        cyc();
        drive_std(1, 1'b0);
        settle();
        check_cdb("fp.got1", 1'b1, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
